// File: rtl/loop_iter_pkg.sv
// Shared types and the index-step arithmetic for the loop iterator FU.
// step_eval works at MAXW bits and masks down to the instance width w.
package loop_iter_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam int unsigned MAXW = 64;

  // Returns {ovf, pred, next}; bits of next above w are always zero.
  function automatic logic [MAXW+1:0] step_eval(input logic [MAXW-1:0] i,
                                                input logic [MAXW-1:0] bnd,
                                                input logic [MAXW-1:0] step,
                                                input int unsigned     w,
                                                input logic            sgn);
    logic [MAXW:0]   sum;
    logic [MAXW:0]   carry_bit;
    logic [MAXW-1:0] mask, sbit, nxt, bm;
    logic            ovf, lt, si, ss, sn;
    mask      = (MAXW'(1) << w) - MAXW'(1);
    sbit      = MAXW'(1) << (w - 1);
    carry_bit = (MAXW+1)'(1) << w;
    sum       = {1'b0, i & mask} + {1'b0, step & mask};
    nxt       = sum[MAXW-1:0] & mask;
    bm        = bnd & mask;
    si        = |(i & sbit);
    ss        = |(step & sbit);
    sn        = |(nxt & sbit);
    if (sgn) begin
      ovf = (si == ss) && (sn != si);
      // flipping the sign bit turns a signed compare into an unsigned one
      lt  = (nxt ^ sbit) < (bm ^ sbit);
    end else begin
      ovf = |(sum & carry_bit);
      lt  = nxt < bm;
    end
    return {ovf, lt && !ovf, nxt};
  endfunction

endpackage

// File: rtl/loop_iter_calc.sv
// Combinational datapath: next index, overflow, loop predicate and the
// base+idx address adders for one token.
module loop_iter_calc
  import loop_iter_pkg::*;
#(
  parameter int           W      = 32,
  parameter logic [W-1:0] STEP   = W'(1),
  parameter int           NADDR  = 1,
  parameter int           SIGNED = 0
) (
  input  logic [W-1:0]       idx_i,
  input  logic [W-1:0]       bound_i,
  input  logic [NADDR*W-1:0] base_i,
  output logic [W-1:0]       next_o,
  output logic               pred_o,
  output logic               ovf_o,
  output logic [NADDR*W-1:0] addr_o
);

  logic [MAXW+1:0] res;
  logic            calc_unused;

  assign res    = step_eval(MAXW'(idx_i), MAXW'(bound_i), MAXW'(STEP), W, SIGNED != 0);
  assign next_o = res[W-1:0];
  assign pred_o = res[MAXW];
  assign ovf_o  = res[MAXW+1];
  assign calc_unused = ^res[MAXW-1:0];

  for (genvar k = 0; k < NADDR; k++) begin : g_addr
    assign addr_o[k*W +: W] = base_i[k*W +: W] + idx_i;
  end

endmodule

// File: rtl/loop_iter_fu.sv
// Handshaked loop iterator: single-step (AUTO=0) or self-iterating (AUTO=1)
// with a registered output stage and valid/ready on both sides.
module loop_iter_fu
  import loop_iter_pkg::*;
#(
  parameter int           W      = 32,
  parameter logic [W-1:0] STEP   = W'(1),
  parameter int           NPRED  = 4,
  parameter int           NADDR  = 1,
  parameter int           SIGNED = 0,
  parameter int           AUTO   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_idx,
  input  logic [W-1:0]       in_bound,
  input  logic [NADDR*W-1:0] in_base,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NPRED-1:0]   out_pred,
  output logic [W-1:0]       out_next,
  output logic [NADDR*W-1:0] out_addr,
  output logic               out_last,
  output logic               out_ovf,
  output logic               busy
);

  state_e             state_q;
  logic [W-1:0]       i_q, bound_q, next_q;
  logic [NADDR*W-1:0] base_q, addr_q;
  logic               out_valid_q, pred_q, last_q, ovf_q;

  logic               load_en, run, take;
  logic [W-1:0]       c_idx, c_bound, c_next;
  logic [NADDR*W-1:0] c_base, c_addr;
  logic               c_pred, c_ovf;

  assign load_en  = !out_valid_q || out_ready;
  assign run      = (AUTO != 0) && (state_q == ST_RUN);
  assign in_ready = load_en && !run;
  assign take     = load_en && (run || in_valid);
  assign c_idx    = run ? i_q     : in_idx;
  assign c_bound  = run ? bound_q : in_bound;
  assign c_base   = run ? base_q  : in_base;

  loop_iter_calc #(.W(W), .STEP(STEP), .NADDR(NADDR), .SIGNED(SIGNED)) u_calc (
    .idx_i   (c_idx),
    .bound_i (c_bound),
    .base_i  (c_base),
    .next_o  (c_next),
    .pred_o  (c_pred),
    .ovf_o   (c_ovf),
    .addr_o  (c_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      bound_q     <= '0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      next_q      <= '0;
      addr_q      <= '0;
      pred_q      <= 1'b0;
      last_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= take;
      if (take) begin
        next_q <= c_next;
        addr_q <= c_addr;
        pred_q <= c_pred;
        ovf_q  <= c_ovf;
        last_q <= !c_pred;
        if (AUTO != 0) begin
          i_q <= c_next;
          if (!run) begin
            bound_q <= in_bound;
            base_q  <= in_base;
          end
          state_q <= c_pred ? ST_RUN : ST_IDLE;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_pred  = {NPRED{pred_q}};
  assign out_next  = next_q;
  assign out_addr  = addr_q;
  assign out_last  = last_q;
  assign out_ovf   = ovf_q;
  assign busy      = run;

endmodule

// File: tb/tb_loop_iter_fu.sv
// Directed bench: single-step unsigned and signed instances plus a
// self-iterating instance sharing data inputs and out_ready.
module tb_loop_iter_fu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in_idx, in_bound, in_base;
  logic        out_ready;
  logic        v0, v1, v2;
  int          checks = 0;
  int          failures = 0;

  logic        r0, ov0, l0, f0, b0;
  logic [3:0]  p0;
  logic [31:0] n0, a0;
  logic        r1, ov1, l1, f1, b1;
  logic [3:0]  p1;
  logic [31:0] n1, a1;
  logic        r2, ov2, l2, f2, b2;
  logic [3:0]  p2;
  logic [31:0] n2, a2;

  always #5 clk = ~clk;

  loop_iter_fu #(.W(32), .NPRED(4), .NADDR(1), .SIGNED(0), .AUTO(0)) u_step (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_idx(in_idx),
    .in_bound(in_bound), .in_base(in_base), .out_valid(ov0), .out_ready(out_ready),
    .out_pred(p0), .out_next(n0), .out_addr(a0), .out_last(l0), .out_ovf(f0), .busy(b0));

  loop_iter_fu #(.W(32), .NPRED(4), .NADDR(1), .SIGNED(1), .AUTO(0)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_idx(in_idx),
    .in_bound(in_bound), .in_base(in_base), .out_valid(ov1), .out_ready(out_ready),
    .out_pred(p1), .out_next(n1), .out_addr(a1), .out_last(l1), .out_ovf(f1), .busy(b1));

  loop_iter_fu #(.W(32), .NPRED(4), .NADDR(1), .SIGNED(0), .AUTO(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2), .in_idx(in_idx),
    .in_bound(in_bound), .in_base(in_base), .out_valid(ov2), .out_ready(out_ready),
    .out_pred(p2), .out_next(n2), .out_addr(a2), .out_last(l2), .out_ovf(f2), .busy(b2));

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov0, p0, n0, a0, l0, f0, b0} !== 71'd0) begin
      failures++;
      $display("FAIL reset_step got=%h exp=0", {ov0, p0, n0, a0, l0, f0, b0});
    end
    checks++;
    if ({ov2, p2, n2, a2, l2, f2, b2} !== 71'd0) begin
      failures++;
      $display("FAIL reset_auto got=%h exp=0", {ov2, p2, n2, a2, l2, f2, b2});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_step();
    @(negedge clk);
    v0 = 1'b1; in_idx = 32'd5; in_bound = 32'd7; in_base = 32'd100; out_ready = 1'b1;
    #1;
    checks++;
    if (r0 !== 1'b1) begin failures++; $display("FAIL step_in_ready got=%b exp=1", r0); end
    @(posedge clk); #1;
    checks++;
    if ({ov0, n0, p0, a0, f0, l0} !== {1'b1, 32'd6, 4'hF, 32'd105, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL step_tok1 got=%h exp=%h", {ov0, n0, p0, a0, f0, l0},
               {1'b1, 32'd6, 4'hF, 32'd105, 1'b0, 1'b0});
    end
    in_idx = 32'd6;
    @(posedge clk); #1;
    checks++;
    if ({ov0, n0, p0, a0, f0, l0} !== {1'b1, 32'd7, 4'h0, 32'd106, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL step_tok2 got=%h exp=%h", {ov0, n0, p0, a0, f0, l0},
               {1'b1, 32'd7, 4'h0, 32'd106, 1'b0, 1'b1});
    end
    checks++;
    if (b0 !== 1'b0) begin failures++; $display("FAIL step_busy got=%b exp=0", b0); end
    v0 = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (r0 !== 1'b0) begin failures++; $display("FAIL step_stall_ready got=%b exp=0", r0); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (r0 !== 1'b1) begin failures++; $display("FAIL step_ready_no_valid got=%b exp=1", r0); end
    @(posedge clk); #1;
    checks++;
    if (ov0 !== 1'b0) begin failures++; $display("FAIL step_drain got=%b exp=0", ov0); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    v0 = 1'b1; v1 = 1'b1; out_ready = 1'b1;
    in_idx = 32'hFFFF_FFFF; in_bound = 32'hFFFF_FFFF; in_base = 32'd0;
    @(posedge clk); #1;
    checks++;
    if ({n0, f0, p0, l0} !== {32'd0, 1'b1, 4'h0, 1'b1}) begin
      failures++;
      $display("FAIL wrap_unsigned got=%h exp=%h", {n0, f0, p0, l0}, {32'd0, 1'b1, 4'h0, 1'b1});
    end
    in_idx = 32'h7FFF_FFFF; in_bound = 32'h7FFF_FFFF;
    @(posedge clk); #1;
    checks++;
    if ({n1, f1, p1} !== {32'h8000_0000, 1'b1, 4'h0}) begin
      failures++;
      $display("FAIL wrap_signed got=%h exp=%h", {n1, f1, p1}, {32'h8000_0000, 1'b1, 4'h0});
    end
    in_idx = 32'hFFFF_FFFB; in_bound = 32'd0;
    @(posedge clk); #1;
    checks++;
    if ({n1, f1, p1} !== {32'hFFFF_FFFC, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL cmp_signed got=%h exp=%h", {n1, f1, p1}, {32'hFFFF_FFFC, 1'b0, 4'hF});
    end
    checks++;
    if ({n0, f0, p0} !== {32'hFFFF_FFFC, 1'b0, 4'h0}) begin
      failures++;
      $display("FAIL cmp_unsigned got=%h exp=%h", {n0, f0, p0}, {32'hFFFF_FFFC, 1'b0, 4'h0});
    end
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_auto_loop();
    logic        pr;
    logic [70:0] exp;
    @(negedge clk);
    v2 = 1'b1; in_idx = 32'd0; in_bound = 32'd3; in_base = 32'h40; out_ready = 1'b1;
    #1;
    checks++;
    if (r2 !== 1'b1) begin failures++; $display("FAIL auto_start_ready got=%b exp=1", r2); end
    @(posedge clk); #1;
    v2 = 1'b0;
    in_idx = 32'd99; in_bound = 32'd99; in_base = 32'h0;
    for (int k = 0; k < 3; k++) begin
      pr  = (k < 2);
      exp = {1'b1, 32'(k + 1), 32'h40 + 32'(k), {4{pr}}, !pr, pr};
      checks++;
      if ({ov2, n2, a2, p2, l2, b2} !== exp || r2 !== !pr) begin
        failures++;
        $display("FAIL auto_tok%0d got=%h rdy=%b exp=%h rdy=%b", k,
                 {ov2, n2, a2, p2, l2, b2}, r2, exp, !pr);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (ov2 !== 1'b0) begin failures++; $display("FAIL auto_end_valid got=%b exp=0", ov2); end
  endtask

  task automatic test_auto_backpressure();
    logic [70:0] exp;
    @(negedge clk);
    v2 = 1'b1; in_idx = 32'd0; in_bound = 32'd3; in_base = 32'h40; out_ready = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0; out_ready = 1'b0;
    exp = {1'b1, 32'd1, 32'h40, 4'hF, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      checks++;
      if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
        failures++;
        $display("FAIL bp_hold%0d got=%h exp=%h", s, {ov2, n2, a2, p2, l2, b2}, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    exp = {1'b1, 32'd2, 32'h41, 4'hF, 1'b0, 1'b1};
    checks++;
    if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
      failures++;
      $display("FAIL bp_tok2 got=%h exp=%h", {ov2, n2, a2, p2, l2, b2}, exp);
    end
    @(posedge clk); #1;
    exp = {1'b1, 32'd3, 32'h42, 4'h0, 1'b1, 1'b0};
    checks++;
    if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
      failures++;
      $display("FAIL bp_tok3 got=%h exp=%h", {ov2, n2, a2, p2, l2, b2}, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (ov2 !== 1'b0) begin failures++; $display("FAIL bp_count got=%b exp=0", ov2); end
  endtask

  task automatic test_auto_boundary();
    logic [70:0] exp;
    @(negedge clk);
    v2 = 1'b1; in_idx = 32'd9; in_bound = 32'd5; in_base = 32'h40; out_ready = 1'b1;
    @(posedge clk); #1;
    exp = {1'b1, 32'd10, 32'h49, 4'h0, 1'b1, 1'b0};
    checks++;
    if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
      failures++;
      $display("FAIL bnd_single got=%h exp=%h", {ov2, n2, a2, p2, l2, b2}, exp);
    end
    in_idx = 32'd1; in_bound = 32'd3;
    #1;
    checks++;
    if (r2 !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", r2); end
    @(posedge clk); #1;
    v2 = 1'b0;
    exp = {1'b1, 32'd2, 32'h41, 4'hF, 1'b0, 1'b1};
    checks++;
    if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
      failures++;
      $display("FAIL b2b_tok1 got=%h exp=%h", {ov2, n2, a2, p2, l2, b2}, exp);
    end
    @(posedge clk); #1;
    exp = {1'b1, 32'd3, 32'h42, 4'h0, 1'b1, 1'b0};
    checks++;
    if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
      failures++;
      $display("FAIL b2b_tok2 got=%h exp=%h", {ov2, n2, a2, p2, l2, b2}, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midloop();
    logic [70:0] exp;
    @(negedge clk);
    v2 = 1'b1; in_idx = 32'd0; in_bound = 32'd3; in_base = 32'h40; out_ready = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({ov2, n2, a2, p2, l2, f2, b2} !== 71'd0) begin
      failures++;
      $display("FAIL rst_mid got=%h exp=0", {ov2, n2, a2, p2, l2, f2, b2});
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (b2 !== 1'b0 || ov2 !== 1'b0) begin
      failures++;
      $display("FAIL rst_release got=%b%b exp=00", b2, ov2);
    end
    v2 = 1'b1; in_idx = 32'd0; in_bound = 32'd1; in_base = 32'h40; out_ready = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    exp = {1'b1, 32'd1, 32'h40, 4'h0, 1'b1, 1'b0};
    checks++;
    if ({ov2, n2, a2, p2, l2, b2} !== exp) begin
      failures++;
      $display("FAIL rst_fresh got=%h exp=%h", {ov2, n2, a2, p2, l2, b2}, exp);
    end
  endtask

  initial begin
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; out_ready = 1'b0;
    in_idx = '0; in_bound = '0; in_base = '0;
    test_reset();
    test_single_step();
    test_wrap();
    test_auto_loop();
    test_auto_backpressure();
    test_auto_boundary();
    test_reset_midloop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
